// File: rtl/mn_pkg.sv
// Shared types for the M/N result collector: FSM states, address width and FIFO entry layout.
package mn_pkg;

  localparam int MN_WIDTH  = 8;
  localparam int MN_DATA_W = 16;
  localparam int MN_ADDR_W = 2 * MN_WIDTH;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2
  } mn_state_e;

  // Default-width entry; the collector derives the same layout from its own parameters.
  typedef struct packed {
    logic [MN_ADDR_W-1:0] addr;
    logic [MN_DATA_W-1:0] data;
  } mn_entry_t;

  function automatic int mn_addr_w(input int w);
    return 2 * w;
  endfunction

endpackage

// File: rtl/mn_sync_fifo.sv
// Single-clock FIFO with flush; a push is accepted while full when a pop happens in the same cycle.
module mn_sync_fifo #(
  parameter int Width = 32,
  parameter int Depth = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [Width-1:0]           data_i,
  input  logic                       pop_i,
  output logic [Width-1:0]           data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(Depth):0]     count_o
);

  localparam int PtrW = $clog2(Depth);
  localparam logic [PtrW:0] PtrOne = (PtrW+1)'(1);

  logic [Width-1:0] mem [Depth];
  logic [PtrW:0]    wptr_q, rptr_q;
  logic             push_ok, pop_ok;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[PtrW] != rptr_q[PtrW]) &&
                   (wptr_q[PtrW-1:0] == rptr_q[PtrW-1:0]);
  assign count_o = wptr_q - rptr_q;
  assign data_o  = mem[rptr_q[PtrW-1:0]];

  assign pop_ok  = pop_i && !empty_o && !flush_i;
  assign push_ok = push_i && !flush_i && (!full_o || pop_ok);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else if (flush_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + PtrOne;
      if (pop_ok)  rptr_q <= rptr_q + PtrOne;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wptr_q[PtrW-1:0]] <= data_i;
  end

endmodule

// File: rtl/mn_result_collector.sv
// Collects (M,N)-tagged array results, maps them to row-major addresses and drains them to memory.
// Optional in-order index checking is built when MN_COLLECTOR_SEQ_CHECK_EN is defined.
module mn_result_collector
  import mn_pkg::*;
#(
  parameter int Width     = MN_WIDTH,
  parameter int DataWidth = MN_DATA_W,
  parameter int Depth     = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic [Width-1:0]       M_size_i,
  input  logic [Width-1:0]       N_size_i,
  input  logic                   in_valid_i,
  input  logic [Width-1:0]       in_M_i,
  input  logic [Width-1:0]       in_N_i,
  input  logic [DataWidth-1:0]   in_data_i,
  input  logic                   in_last_i,
  output logic                   wr_valid_o,
  input  logic                   wr_ready_i,
  output logic [2*Width-1:0]     wr_addr_o,
  output logic [DataWidth-1:0]   wr_data_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   overflow_o,
  output logic                   seq_err_o
);

  localparam int AddrW = mn_addr_w(Width);
  localparam int CntW  = $clog2(Depth) + 1;

  typedef struct packed {
    logic [AddrW-1:0]     addr;
    logic [DataWidth-1:0] data;
  } entry_t;

  mn_state_e        state_q, state_d;
  logic             done_q, done_d;
  logic             ovf_q;
  logic [Width-1:0] n_size_q;
  logic             push_req, pop, fifo_full, fifo_empty;
  logic [CntW-1:0]  fifo_cnt;
  logic [AddrW-1:0] addr_calc;
  entry_t           push_entry, head;

  assign push_req  = (state_q == COLLECT) && in_valid_i && !start_i;
  assign pop       = !fifo_empty && wr_ready_i && !start_i;
  assign addr_calc = AddrW'(in_M_i) * AddrW'(n_size_q) + AddrW'(in_N_i);

  assign push_entry.addr = addr_calc;
  assign push_entry.data = in_data_i;

  mn_sync_fifo #(
    .Width ($bits(entry_t)),
    .Depth (Depth)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (start_i),
    .push_i  (push_req),
    .data_i  (push_entry),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  // Leaving DRAIN on the cycle the final entry transfers makes done/busy line up one cycle later.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    if (start_i) begin
      state_d = COLLECT;
    end else begin
      case (state_q)
        IDLE:    state_d = IDLE;
        COLLECT: if (in_valid_i && in_last_i) state_d = DRAIN;
        DRAIN: begin
          if (fifo_empty || (pop && fifo_cnt == CntW'(1))) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      if (start_i)
        ovf_q <= 1'b0;
      else if (push_req && fifo_full && !pop)
        ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (start_i) n_size_q <= N_size_i;
  end

  assign wr_valid_o = !fifo_empty;
  assign wr_addr_o  = wr_valid_o ? head.addr : '0;
  assign wr_data_o  = wr_valid_o ? head.data : '0;
  assign busy_o     = (state_q != IDLE);
  assign done_o     = done_q;
  assign overflow_o = ovf_q;

`ifdef MN_COLLECTOR_SEQ_CHECK_EN
  logic [Width-1:0] m_size_q;
  logic [Width-1:0] exp_m_q, exp_n_q;
  logic             seq_q;
  logic             idx_bad, last_bad;

  always_ff @(posedge clk_i) begin
    if (start_i) m_size_q <= M_size_i;
  end

  assign idx_bad  = (in_M_i != exp_m_q) || (in_N_i != exp_n_q);
  assign last_bad = in_last_i &&
                    ((in_M_i != m_size_q - Width'(1)) || (in_N_i != n_size_q - Width'(1)));

  // Counter advances from its own expected value so one bad index flags once, not forever.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      exp_m_q <= '0;
      exp_n_q <= '0;
      seq_q   <= 1'b0;
    end else if (start_i) begin
      exp_m_q <= '0;
      exp_n_q <= '0;
      seq_q   <= 1'b0;
    end else if (push_req) begin
      if (idx_bad || last_bad) seq_q <= 1'b1;
      if (exp_n_q == n_size_q - Width'(1)) begin
        exp_n_q <= '0;
        exp_m_q <= (exp_m_q == m_size_q - Width'(1)) ? '0 : exp_m_q + Width'(1);
      end else begin
        exp_n_q <= exp_n_q + Width'(1);
      end
    end
  end

  assign seq_err_o = seq_q;
`else
  logic unused_m_size;
  assign unused_m_size = ^M_size_i;
  assign seq_err_o     = 1'b0;
`endif

endmodule

// File: doc/mn_result_collector.md
# mn_result_collector

Drain-side counterpart of the ripple M/N index chain. Sits at the output edge of the systolic array and accepts one (M,N)-tagged result per cycle with no backpressure. Buffers results in a small FIFO and converts each tag to a row-major linear address. Presents address/data to the output-memory writer over a valid/ready handshake, and signals completion once the last index has been written.

## Interface
- `Width`, 8, bit width of M/N indices and sizes
- `DataWidth`, 16, result data width
- `Depth`, 4, FIFO entries (power of two, ≥2)
- `clk_i`  in  1  clock, rising edge
- `rst_ni`  in  1  asynchronous active-low reset
- `start_i`  in  1  arm/restart pulse; sizes sampled on this cycle
- `M_size_i`  in  Width  row count (≥1)
- `N_size_i`  in  Width  column count (≥1)
- `in_valid_i`  in  1  result present on this cycle (no ready returned)
- `in_M_i`  in  Width  row index of result
- `in_N_i`  in  Width  column index of result
- `in_data_i`  in  DataWidth  result value
- `in_last_i`  in  1  marks the final result of the tile
- `wr_valid_o`  out  1  write request to output memory
- `wr_ready_i`  in  1  output memory accepts the request
- `wr_addr_o`  out  2*Width  linear address M*N_size+N
- `wr_data_o`  out  DataWidth  write data
- `busy_o`  out  1  high in COLLECT or DRAIN
- `done_o`  out  1  one-cycle pulse when the tile is fully written
- `overflow_o`  out  1  sticky: a result was dropped
- `seq_err_o`  out  1  sticky: out-of-order index (see Configuration)

## Operation
- Index space: N in 0..N_size-1 is the fastest-varying index, M in 0..M_size-1; last = (M_size-1, N_size-1).
- Sizes are latched on `start_i`. Address uses the latched N_size. Product is 2*Width wide with no truncation.
- FSM states: IDLE, COLLECT, DRAIN.
  - IDLE: `start_i` → COLLECT. `in_valid_i` is ignored and no flags are set.
  - COLLECT: each `in_valid_i` pushes {addr, data}. A push with `in_last_i` → DRAIN.
  - DRAIN: no pushes (`in_valid_i` ignored). When the FIFO is empty and no write is outstanding → pulse `done_o` → IDLE.
- `start_i` in any state restarts: flush FIFO, clear `overflow_o`/`seq_err_o`, reload sizes, → COLLECT. Any input on that cycle is discarded.
- Overflow: a push while the FIFO is full with no pop in the same cycle drops the entry and sets `overflow_o`. A simultaneous push and pop while full is legal and loses nothing.
- Handshake: a write transfers when `wr_valid_o & wr_ready_i`. `wr_addr_o`/`wr_data_o` hold stable while valid and not ready. `wr_valid_o` never drops without a transfer, except on restart or reset.
- `in_last_i` ends collection even if fewer than M_size*N_size results arrived.

## Timing
- Reset state: IDLE. Reset values: `wr_valid_o`=0, `wr_addr_o`=0, `wr_data_o`=0, `busy_o`=0, `done_o`=0, `overflow_o`=0, `seq_err_o`=0, FIFO empty.
- Push at edge k → `wr_valid_o` high after edge k. Input-to-write latency is 1 cycle when `wr_ready_i`=1. Throughput is 1 per cycle.
- `busy_o` rises the cycle after `start_i`.
- `done_o` is asserted for the single cycle after the last transfer edge. `busy_o` falls in that same cycle.
- Reset mid-operation is asynchronous: all state and outputs return to reset values immediately.

## Configuration
- `MN_COLLECTOR_SEQ_CHECK_EN` defined: builds an expected (M,N) counter. The counter starts at (0,0) on `start_i` and advances N-first, wrapping at the latched sizes, on each accepted push.
  - A push whose index ≠ expected sets `seq_err_o`. The entry is still written, and the counter advances from the expected value, not the received one.
  - `in_last_i` on an index ≠ (M_size-1, N_size-1) also sets `seq_err_o`.
- Undefined: no expected counter; `seq_err_o` is tied to 0.

## Structure
- Package `mn_pkg`: state enum typedef (IDLE/COLLECT/DRAIN), address-width constant 2*Width, and a packed FIFO entry struct {addr, data}.
- Sub-module `mn_sync_fifo`: single-clock FIFO with async reset, flush, full/empty, and same-cycle push+pop when full. The collector holds the FSM, address multiply, flags and sequence checker.

## Test plan
- Sizes 3x4, stream (0,0)..(2,3) every cycle, `wr_ready_i`=1 → 12 writes at addr 0..11 in order; `done_o` pulses once, 1 cycle after the last transfer.
- Same stream with `wr_ready_i` low for 3 cycles mid-tile, `Depth`=4 → stalled entry is held stable, no overflow, all 12 writes complete.
- `wr_ready_i`=0 throughout, 6 inputs → 4 buffered, `overflow_o`=1; after ready rises, exactly 4 writes, then `done_o`.
- Macro on: feed (0,0),(0,2),(0,1) → `seq_err_o` sets at (0,2) and stays set; all three entries are written at addr 0,2,1.
- `start_i` in COLLECT with 2 entries queued → FIFO flushed, flags cleared, new sizes 2x2 are used for addresses, no `done_o` for the aborted tile.
- Assert `rst_ni`=0 while `wr_valid_o`=1 → all outputs 0 immediately; `in_valid_i` in IDLE afterwards causes no write.
